// File: rtl/game_pkg.sv
// Shared state codes for the snake game controller and its downstream units.
// Render and move logic import this package to decode game_status.
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESTART  = 3'd0,
        ST_START    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_DIE      = 3'd3,
        ST_PAUSE    = 3'd4,
        ST_GAMEOVER = 3'd5
    } game_state_e;

    localparam logic [STATE_W-1:0] GS_RESTART  = 3'd0;
    localparam logic [STATE_W-1:0] GS_START    = 3'd1;
    localparam logic [STATE_W-1:0] GS_PLAY     = 3'd2;
    localparam logic [STATE_W-1:0] GS_DIE      = 3'd3;
    localparam logic [STATE_W-1:0] GS_PAUSE    = 3'd4;
    localparam logic [STATE_W-1:0] GS_GAMEOVER = 3'd5;

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Key/collision inputs and game status outputs of the game controller.
// master drives keys and collisions, slave is the controller itself.
interface game_ctrl_fsm_if #(
    parameter int KEY_N = 4,
    parameter int LIVES = 3
);
    localparam int LIVES_W = $clog2(LIVES + 1);

    logic [KEY_N-1:0]               key_press;
    logic                           hit_wall;
    logic                           hit_body;
    logic [game_pkg::STATE_W-1:0]   game_status;
    logic                           die_flash;
    logic                           restart;
    logic [LIVES_W-1:0]             lives_left;
    logic                           game_over;

    modport master (
        output key_press, hit_wall, hit_body,
        input  game_status, die_flash, restart, lives_left, game_over
    );

    modport slave (
        input  key_press, hit_wall, hit_body,
        output game_status, die_flash, restart, lives_left, game_over
    );

endinterface

// File: rtl/game_flash_timer.sv
// Death-flash cadence: a toggle every FLASH_PERIOD enabled cycles, FLASH_TOGGLES
// times, then done on the following period boundary.
module game_flash_timer #(
    parameter int FLASH_TOGGLES = 9,
    parameter int FLASH_PERIOD  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic enable,
    output logic toggle_pulse,
    output logic done
);
    localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam int TW = (FLASH_TOGGLES > 0) ? $clog2(FLASH_TOGGLES + 1) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(FLASH_PERIOD - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(FLASH_TOGGLES);

    logic [PW-1:0] period_cnt_reg;
    logic [TW-1:0] toggle_cnt_reg;
    logic          boundary;

    assign boundary     = enable && (period_cnt_reg == PERIOD_LAST);
    assign toggle_pulse = boundary && (toggle_cnt_reg != TOGGLE_LAST);
    assign done         = boundary && (toggle_cnt_reg == TOGGLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_reg <= '0;
            toggle_cnt_reg <= '0;
        end else if (start) begin
            period_cnt_reg <= '0;
            toggle_cnt_reg <= '0;
        end else if (enable) begin
            if (boundary) begin
                period_cnt_reg <= '0;
                if (toggle_pulse) begin
                    toggle_cnt_reg <= toggle_cnt_reg + TW'(1);
                end
            end else begin
                period_cnt_reg <= period_cnt_reg + PW'(1);
            end
        end
    end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Snake game phase sequencer: restart/start/play/pause/die/game-over with a
// life counter and a parametrised death-flash cadence. All outputs registered.
module game_ctrl_fsm
    import game_pkg::*;
#(
    parameter int KEY_N          = 4,
    parameter int PAUSE_KEY      = 0,
    parameter int LIVES          = 3,
    parameter int RESTART_CYCLES = 6,
    parameter int FLASH_TOGGLES  = 9,
    parameter int FLASH_PERIOD   = 1
) (
    input logic           clk,
    input logic           rst,
    game_ctrl_fsm_if.slave bus
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int RW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
    localparam logic [LW-1:0] LIVES_INIT   = LW'(LIVES);
    localparam logic [RW-1:0] RESTART_LAST = RW'(RESTART_CYCLES - 1);

    game_state_e   state_reg;
    logic          die_flash_reg;
    logic          restart_reg;
    logic          game_over_reg;
    logic [LW-1:0] lives_reg;
    logic [RW-1:0] restart_cnt_reg;

    logic [KEY_N-1:0] keys;
    logic             any_key;
    logic             pause_key;
    logic             collide;
    logic             flash_start;
    logic             flash_enable;
    logic             flash_toggle;
    logic             flash_done;

    assign keys      = bus.key_press;
    assign any_key   = |keys;
    assign pause_key = keys[PAUSE_KEY];
    assign collide   = bus.hit_wall | bus.hit_body;

    // Counters are cleared on the PLAY->DIE edge so each death starts a fresh cadence.
    assign flash_start  = (state_reg == ST_PLAY) && collide;
    assign flash_enable = (state_reg == ST_DIE);

    game_flash_timer #(
        .FLASH_TOGGLES (FLASH_TOGGLES),
        .FLASH_PERIOD  (FLASH_PERIOD)
    ) u_flash_timer (
        .clk          (clk),
        .rst          (rst),
        .start        (flash_start),
        .enable       (flash_enable),
        .toggle_pulse (flash_toggle),
        .done         (flash_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_START;
            die_flash_reg   <= 1'b1;
            restart_reg     <= 1'b0;
            game_over_reg   <= 1'b0;
            lives_reg       <= LIVES_INIT;
            restart_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_RESTART: begin
                    if (restart_cnt_reg == RESTART_LAST) begin
                        state_reg       <= ST_START;
                        restart_reg     <= 1'b0;
                        restart_cnt_reg <= '0;
                    end else begin
                        restart_cnt_reg <= restart_cnt_reg + RW'(1);
                    end
                end
                ST_START: begin
                    if (any_key) state_reg <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (collide)        state_reg <= ST_DIE;
                    else if (pause_key) state_reg <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (pause_key) state_reg <= ST_PLAY;
                end
                ST_DIE: begin
                    if (flash_done) begin
                        die_flash_reg <= 1'b1;
                        if (lives_reg != '0) lives_reg <= lives_reg - LW'(1);
                        // Last life (or none left) ends the game instead of restarting.
                        if (lives_reg <= LW'(1)) begin
                            state_reg     <= ST_GAMEOVER;
                            game_over_reg <= 1'b1;
                        end else begin
                            state_reg       <= ST_RESTART;
                            restart_reg     <= 1'b1;
                            restart_cnt_reg <= '0;
                        end
                    end else if (flash_toggle) begin
                        die_flash_reg <= ~die_flash_reg;
                    end
                end
                ST_GAMEOVER: begin
                    die_flash_reg <= 1'b1;
                    if (any_key) begin
                        lives_reg       <= LIVES_INIT;
                        game_over_reg   <= 1'b0;
                        state_reg       <= ST_RESTART;
                        restart_reg     <= 1'b1;
                        restart_cnt_reg <= '0;
                    end
                end
                default: state_reg <= ST_START;
            endcase
        end
    end

    assign bus.game_status = state_reg;
    assign bus.die_flash   = die_flash_reg;
    assign bus.restart     = restart_reg;
    assign bus.lives_left  = lives_reg;
    assign bus.game_over   = game_over_reg;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Two controllers (flash period 1 and 4) driven with identical stimulus and
// checked every cycle against an elapsed-time model of the game phases.
module tb_game_ctrl_fsm;
    import game_pkg::*;

    localparam int KEY_N = 4;
    localparam int LIVES = 3;
    localparam int RC    = 6;
    localparam int FT    = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [KEY_N-1:0] key = '0;
    logic             hw  = 1'b0;
    logic             hb  = 1'b0;

    game_ctrl_fsm_if #(.KEY_N(KEY_N), .LIVES(LIVES)) bus0 ();
    game_ctrl_fsm_if #(.KEY_N(KEY_N), .LIVES(LIVES)) bus1 ();

    assign bus0.key_press = key;
    assign bus0.hit_wall  = hw;
    assign bus0.hit_body  = hb;
    assign bus1.key_press = key;
    assign bus1.hit_wall  = hw;
    assign bus1.hit_body  = hb;

    game_ctrl_fsm #(.KEY_N(KEY_N), .PAUSE_KEY(0), .LIVES(LIVES), .RESTART_CYCLES(RC),
                    .FLASH_TOGGLES(FT), .FLASH_PERIOD(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    game_ctrl_fsm #(.KEY_N(KEY_N), .PAUSE_KEY(0), .LIVES(LIVES), .RESTART_CYCLES(RC),
                    .FLASH_TOGGLES(FT), .FLASH_PERIOD(4))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int st_o [2];
    int fl_o [2];
    int rs_o [2];
    int lv_o [2];
    int go_o [2];
    assign st_o[0] = int'(bus0.game_status);
    assign st_o[1] = int'(bus1.game_status);
    assign fl_o[0] = int'(bus0.die_flash);
    assign fl_o[1] = int'(bus1.die_flash);
    assign rs_o[0] = int'(bus0.restart);
    assign rs_o[1] = int'(bus1.restart);
    assign lv_o[0] = int'(bus0.lives_left);
    assign lv_o[1] = int'(bus1.lives_left);
    assign go_o[0] = int'(bus0.game_over);
    assign go_o[1] = int'(bus1.game_over);

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: phases tracked by elapsed cycles in each phase.
    int per  [2] = '{1, 4};
    int m_st [2];
    int m_fl [2];
    int m_rs [2];
    int m_lv [2];
    int m_go [2];
    int m_rt [2];
    int m_dt [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 1; m_fl[i] = 1; m_rs[i] = 0; m_lv[i] = LIVES;
            m_go[i] = 0; m_rt[i] = 0; m_dt[i] = 0;
        end
    endfunction

    function automatic void model_step(logic [KEY_N-1:0] k, logic w, logic b);
        for (int i = 0; i < 2; i++) begin
            case (m_st[i])
                0: begin
                    m_rt[i]++;
                    if (m_rt[i] == RC) begin m_st[i] = 1; m_rs[i] = 0; m_rt[i] = 0; end
                end
                1: if (k != 0) m_st[i] = 2;
                2: begin
                    if (w || b) begin m_st[i] = 3; m_dt[i] = 0; end
                    else if (k[0]) m_st[i] = 4;
                end
                4: if (k[0]) m_st[i] = 2;
                3: begin
                    m_dt[i]++;
                    if (m_dt[i] == (FT + 1) * per[i]) begin
                        m_fl[i] = 1;
                        if (m_lv[i] > 0) m_lv[i]--;
                        if (m_lv[i] == 0) begin m_st[i] = 5; m_go[i] = 1; end
                        else begin m_st[i] = 0; m_rs[i] = 1; m_rt[i] = 0; end
                    end else begin
                        m_fl[i] = ((m_dt[i] / per[i]) % 2 == 0) ? 1 : 0;
                    end
                end
                5: if (k != 0) begin
                    m_lv[i] = LIVES; m_go[i] = 0; m_st[i] = 0; m_rs[i] = 1; m_rt[i] = 0;
                end
                default: m_st[i] = 1;
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("d%0d_status", i), st_o[i], m_st[i]);
                chk($sformatf("d%0d_flash", i),  fl_o[i], m_fl[i]);
                chk($sformatf("d%0d_restart", i), rs_o[i], m_rs[i]);
                chk($sformatf("d%0d_lives", i),  lv_o[i], m_lv[i]);
                chk($sformatf("d%0d_gameover", i), go_o[i], m_go[i]);
            end
        end
    end

    // Length of the most recent complete DIE run per DUT (runs cut by rst are discarded).
    int run_len [2] = '{0, 0};
    int die_len [2] = '{0, 0};
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (st_o[i] == 3) run_len[i] <= run_len[i] + 1;
            else begin
                if (run_len[i] > 0 && !rst) die_len[i] <= run_len[i];
                run_len[i] <= 0;
            end
        end
    end

    task automatic cyc(input logic [KEY_N-1:0] k, input logic w, input logic b);
        key = k; hw = w; hb = b;
        @(posedge clk);
        if (!rst) model_step(k, w, b);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_status(input int i, input int code, input int bound, input string name);
        int n = 0;
        while (st_o[i] != code && n < bound) begin
            cyc('0, 1'b0, 1'b0);
            n++;
        end
        chk(name, st_o[i], code);
    endtask

    initial begin
        int toggles, prev, n, r;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_status", st_o[0], 1);
        chk("rst_flash", fl_o[0], 1);
        chk("rst_restart", rs_o[0], 0);
        chk("rst_lives", lv_o[0], 3);
        $display("txn reset: status=%0d lives=%0d", st_o[0], lv_o[0]);

        cyc(4'b0010, 1'b0, 1'b0);
        chk("start_to_play", st_o[0], 2);
        $display("txn key 0010: status=%0d", st_o[0]);

        cyc('0, 1'b1, 1'b0);
        chk("wall_to_die", st_o[0], 3);
        toggles = 0; n = 0;
        while (st_o[0] == 3 && n < 100) begin
            prev = fl_o[0];
            cyc('0, 1'b0, 1'b0);
            if (st_o[0] == 3 && fl_o[0] != prev) toggles++;
            n++;
        end
        chk("die_toggles", toggles, 9);
        chk("die_exit_flash", fl_o[0], 1);
        chk("die_exit_lives", lv_o[0], 2);
        chk("die_exit_status", st_o[0], 0);
        r = 0;
        while (rs_o[0] == 1 && r < 100) begin
            r++;
            cyc('0, 1'b0, 1'b0);
        end
        chk("restart_len", r, 6);
        chk("restart_to_start", st_o[0], 1);
        $display("txn death: toggles=%0d restart_len=%0d lives=%0d", toggles, r, lv_o[0]);

        cyc(4'b0001, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0);
        chk("pause_enter", st_o[0], 4);
        cyc('0, 1'b0, 1'b1);
        chk("pause_ignores_hit", st_o[0], 4);
        cyc(4'b0100, 1'b0, 1'b0);
        chk("pause_other_key", st_o[0], 4);
        cyc(4'b0001, 1'b0, 1'b0);
        chk("pause_exit", st_o[0], 2);
        $display("txn pause/resume: status=%0d", st_o[0]);

        cyc(4'b0001, 1'b0, 1'b1);
        chk("hit_beats_pause", st_o[0], 3);
        wait_status(0, 1, 60, "second_death_start");
        chk("second_death_lives", lv_o[0], 1);
        cyc(4'b0010, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0);
        wait_status(0, 5, 60, "gameover_status");
        chk("gameover_flag", go_o[0], 1);
        chk("gameover_lives", lv_o[0], 0);
        chk("gameover_flash", fl_o[0], 1);
        cyc(4'b1000, 1'b0, 1'b0);
        chk("reload_lives", lv_o[0], 3);
        chk("reload_status", st_o[0], 0);
        chk("reload_restart", rs_o[0], 1);
        chk("reload_gameover", go_o[0], 0);
        $display("txn gameover/reload: status=%0d lives=%0d", st_o[0], lv_o[0]);

        do_reset();
        cyc(4'b0010, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0);
        repeat (4) cyc('0, 1'b0, 1'b0);
        chk("mid_die_status", st_o[0], 3);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_status", st_o[0], 1);
        chk("async_rst_flash", fl_o[0], 1);
        chk("async_rst_restart", rs_o[0], 0);
        chk("async_rst_lives", lv_o[0], 3);
        chk("async_rst_status_p4", st_o[1], 1);
        @(posedge clk);
        #1 rst = 1'b0;
        $display("txn async reset mid-die: status=%0d flash=%0d", st_o[0], fl_o[0]);

        cyc(4'b0010, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b1);
        repeat (45) cyc('0, 1'b0, 1'b0);
        chk("die_len_p1", die_len[0], 10);
        chk("die_len_p4", die_len[1], 40);
        $display("txn die length: p1=%0d p4=%0d", die_len[0], die_len[1]);

        for (int c = 0; c < 4000; c++) begin
            logic [KEY_N-1:0] k;
            k = ($urandom_range(0, 5) == 0) ? KEY_N'($urandom) : '0;
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                cyc(k, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
            end
        end
        $display("txn random phase done");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
